// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: per-pin direction, synchronised inputs,
// set/clear output aliases and per-pin edge interrupts folded into one level irq.
module gpio_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       addr,
    input  logic [31:0]       data_in,
    input  logic              wr_enable,
    input  logic              rd_enable,
    output logic [31:0]       data_out,
    input  logic [WIDTH-1:0]  gpio_i,
    output logic [WIDTH-1:0]  gpio_o,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);

    localparam logic [31:0] MASK = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                 : 32'((64'd1 << WIDTH) - 64'd1);
    localparam logic [2:0]  SETTLE_MAX = 3'(SYNC_STAGES + 1);

    localparam logic [2:0] REG_OUT    = 3'd0;
    localparam logic [2:0] REG_DIR    = 3'd1;
    localparam logic [2:0] REG_IN     = 3'd2;
    localparam logic [2:0] REG_IEN    = 3'd3;
    localparam logic [2:0] REG_EDGE   = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;
    localparam logic [2:0] REG_OSET   = 3'd6;
    localparam logic [2:0] REG_OCLR   = 3'd7;

    function automatic logic [31:0] ext(input logic [WIDTH-1:0] v);
        ext = '0;
        ext[WIDTH-1:0] = v;
    endfunction

    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] prev_q;
    logic [31:0] out_q, dir_q, ien_q, edge_q, status_q;
    logic [2:0]  settle_q;
    logic        irq_q;

    logic [2:0]  sel;
    logic [31:0] wdata, in_val, rise, fall, hit;
    logic [31:0] out_nxt, dir_nxt, ien_nxt, edge_nxt, status_nxt, status_clr;
    logic        unused_addr_bits;

    assign sel              = addr[4:2];
    assign unused_addr_bits = ^{addr[63:5], addr[1:0]};
    assign wdata            = data_in & MASK;
    assign in_val           = sync_q[SYNC_STAGES-1];

    always_comb begin
        rise = in_val & ~prev_q;
        fall = ~in_val & prev_q;
        // Edges are ignored until the synchroniser has flushed its reset zeros.
        hit  = '0;
        if (settle_q == SETTLE_MAX)
            hit = ien_q & ((edge_q & rise) | (~edge_q & fall));

        out_nxt    = out_q;
        dir_nxt    = dir_q;
        ien_nxt    = ien_q;
        edge_nxt   = edge_q;
        status_clr = '0;
        if (wr_enable) begin
            case (sel)
                REG_OUT:    out_nxt    = wdata;
                REG_DIR:    dir_nxt    = wdata;
                REG_IEN:    ien_nxt    = wdata;
                REG_EDGE:   edge_nxt   = wdata;
                REG_STATUS: status_clr = wdata;
                REG_OSET:   out_nxt    = out_q | wdata;
                REG_OCLR:   out_nxt    = out_q & ~wdata;
                default:    ;
            endcase
        end
        // A new hit wins over a same-cycle write-one-to-clear.
        status_nxt = (status_q & ~status_clr) | hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q   <= '0;
            out_q    <= '0;
            dir_q    <= '0;
            ien_q    <= '0;
            edge_q   <= '0;
            status_q <= '0;
            settle_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            sync_q[0] <= ext(gpio_i);
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q   <= in_val;
            out_q    <= out_nxt;
            dir_q    <= dir_nxt;
            ien_q    <= ien_nxt;
            edge_q   <= edge_nxt;
            status_q <= status_nxt;
            if (settle_q != SETTLE_MAX) settle_q <= settle_q + 3'd1;
            irq_q    <= |(status_nxt & ien_nxt);
        end
    end

    always_comb begin
        data_out = '0;
        if (rd_enable) begin
            case (sel)
                REG_OUT:    data_out = out_q;
                REG_DIR:    data_out = dir_q;
                REG_IN:     data_out = in_val;
                REG_IEN:    data_out = ien_q;
                REG_EDGE:   data_out = edge_q;
                REG_STATUS: data_out = status_q;
                default:    data_out = '0;
            endcase
        end
    end

    assign gpio_o  = out_q[WIDTH-1:0];
    assign gpio_oe = dir_q[WIDTH-1:0];
    assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: register table plus hand-written edge/irq sequences,
// with a second WIDTH=8 instance for the narrow-build masking.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addr;
    logic [31:0] data_in;
    logic        wr_enable, rd_enable;
    logic [31:0] data_out;
    logic [31:0] gpio_i, gpio_o, gpio_oe;
    logic        irq;

    logic [63:0] addr8;
    logic [31:0] data_in8, data_out8;
    logic        wr8, rd8, irq8;
    logic [7:0]  gpio_i8, gpio_o8, gpio_oe8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .wr_enable(wr_enable), .rd_enable(rd_enable), .data_out(data_out),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
    );

    gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .addr(addr8), .data_in(data_in8),
        .wr_enable(wr8), .rd_enable(rd8), .data_out(data_out8),
        .gpio_i(gpio_i8), .gpio_o(gpio_o8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  wreg;
        logic [31:0] wdata;
        logic [2:0]  rreg;
        logic [31:0] exp_rd;
        logic [31:0] exp_o;
        logic [31:0] exp_oe;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        addr      = {59'd0, r, 2'b00};
        data_in   = d;
        wr_enable = 1'b1;
        @(posedge clk);
        #1;
        wr_enable = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [2:0] r, input logic [31:0] exp);
        addr      = {59'd0, r, 2'b00};
        rd_enable = 1'b1;
        #1;
        check(name, data_out, exp);
        rd_enable = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'd1, 32'h0000_00FF, 3'd1, 32'h0000_00FF, 32'h0,     32'hFF};
        vecs[1] = '{1'b1, 3'd0, 32'h0000_00A5, 3'd0, 32'h0000_00A5, 32'hA5,    32'hFF};
        vecs[2] = '{1'b1, 3'd6, 32'h0000_0100, 3'd0, 32'h0000_01A5, 32'h1A5,   32'hFF};
        vecs[3] = '{1'b1, 3'd7, 32'h0000_0005, 3'd0, 32'h0000_01A0, 32'h1A0,   32'hFF};
        vecs[4] = '{1'b0, 3'd0, 32'h0,         3'd6, 32'h0,         32'h1A0,   32'hFF};
        vecs[5] = '{1'b0, 3'd0, 32'h0,         3'd7, 32'h0,         32'h1A0,   32'hFF};
        vecs[6] = '{1'b1, 3'd2, 32'h0000_1234, 3'd2, 32'hFFFF_FFFF, 32'h1A0,   32'hFF};
        vecs[7] = '{1'b1, 3'd4, 32'h0000_0008, 3'd4, 32'h0000_0008, 32'h1A0,   32'hFF};
        vecs[8] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 3'd0, 32'h0,         32'h0,     32'hFF};
        vecs[9] = '{1'b1, 3'd5, 32'hFFFF_FFFF, 3'd5, 32'h0,         32'h0,     32'hFF};

        rst = 1'b1; addr = '0; data_in = '0; wr_enable = 1'b0; rd_enable = 1'b0;
        gpio_i = 32'hFFFF_FFFF;
        addr8 = '0; data_in8 = '0; wr8 = 1'b0; rd8 = 1'b0; gpio_i8 = '0;
        cyc(3);
        check("rst_gpio_o", gpio_o, 32'h0);
        check("rst_gpio_oe", gpio_oe, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        rd_check("rst_status", 3'd5, 32'h0);

        // Pins already high at reset must not raise edges once enabled.
        rst = 1'b0;
        wr(3'd3, 32'hFFFF_FFFF);
        rd_check("in_after_1", 3'd2, 32'h0);
        cyc(1);
        rd_check("in_after_2", 3'd2, 32'hFFFF_FFFF);
        cyc(5);
        rd_check("settle_status", 3'd5, 32'h0);
        check("settle_irq", {31'd0, irq}, 32'h0);

        wr(3'd3, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) wr(vecs[i].wreg, vecs[i].wdata);
            rd_check($sformatf("vec%0d_rd", i), vecs[i].rreg, vecs[i].exp_rd);
            check($sformatf("vec%0d_o", i), gpio_o, vecs[i].exp_o);
            check($sformatf("vec%0d_oe", i), gpio_oe, vecs[i].exp_oe);
        end

        addr = 64'h0; rd_enable = 1'b0; #1;
        check("rd_disabled", data_out, 32'h0);

        // Rising edge on pin 3 (EDGE[3]=1 from the table), falling on pin 4.
        gpio_i = 32'h0;
        cyc(4);
        wr(3'd3, 32'h0000_0018);
        @(posedge clk); #1;
        gpio_i[3] = 1'b1;
        cyc(1);
        rd_check("p3_in_t1", 3'd2, 32'h0);
        cyc(1);
        rd_check("p3_in_t2", 3'd2, 32'h0000_0008);
        rd_check("p3_status_t2", 3'd5, 32'h0);
        check("p3_irq_t2", {31'd0, irq}, 32'h0);
        cyc(1);
        rd_check("p3_status_t3", 3'd5, 32'h0000_0008);
        check("p3_irq_t3", {31'd0, irq}, 32'h1);

        gpio_i[4] = 1'b1;
        cyc(4);
        rd_check("p4_rise_ignored", 3'd5, 32'h0000_0008);
        gpio_i[4] = 1'b0;
        cyc(4);
        rd_check("p4_fall_sets", 3'd5, 32'h0000_0018);
        wr(3'd5, 32'h0000_0018);
        rd_check("w1c_status", 3'd5, 32'h0);
        check("w1c_irq", {31'd0, irq}, 32'h0);

        // Clearing IEN keeps the pending flag but masks irq.
        gpio_i[3] = 1'b0;
        cyc(4);
        rd_check("p3_fall_ignored", 3'd5, 32'h0);
        gpio_i[3] = 1'b1;
        cyc(4);
        rd_check("p3_again", 3'd5, 32'h0000_0008);
        wr(3'd3, 32'h0000_0010);
        rd_check("mask_status", 3'd5, 32'h0000_0008);
        check("mask_irq", {31'd0, irq}, 32'h0);
        wr(3'd3, 32'h0000_0018);
        check("unmask_irq", {31'd0, irq}, 32'h1);

        // W1C lands on the same edge that records a fresh hit on pin 3.
        gpio_i[3] = 1'b0;
        cyc(4);
        gpio_i[3] = 1'b1;
        cyc(2);
        wr(3'd5, 32'h0000_0008);
        rd_check("collide_status", 3'd5, 32'h0000_0008);
        check("collide_irq", {31'd0, irq}, 32'h1);
        wr(3'd5, 32'h0000_0008);
        rd_check("clear_after", 3'd5, 32'h0);

        // Mid-operation reset drops pending irq and outputs.
        wr(3'd0, 32'h0000_003C);
        gpio_i[3] = 1'b0;
        cyc(4);
        gpio_i[3] = 1'b1;
        cyc(4);
        check("pre_rst_irq", {31'd0, irq}, 32'h1);
        check("pre_rst_o", gpio_o, 32'h3C);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mid_rst_irq", {31'd0, irq}, 32'h0);
        check("mid_rst_o", gpio_o, 32'h0);
        check("mid_rst_oe", gpio_oe, 32'h0);
        rd_check("mid_rst_status", 3'd5, 32'h0);

        // Narrow build: upper register bits read zero.
        addr8 = 64'h0; data_in8 = 32'hFFFF_FFFF; wr8 = 1'b1;
        cyc(1);
        wr8 = 1'b0; rd8 = 1'b1; #1;
        check("w8_out_rd", data_out8, 32'h0000_00FF);
        check("w8_gpio_o", {24'd0, gpio_o8}, 32'h0000_00FF);
        addr8 = 64'h18; #1;
        check("w8_oset_rd", data_out8, 32'h0);
        addr8 = 64'h1C; #1;
        check("w8_oclr_rd", data_out8, 32'h0);
        rd8 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
